tile_sequencer: RTL and testbench

Command-driven controller for one 16-bit computation tile. It accepts a command (a single ALU op, or a multiply-accumulate over N operand pairs). It streams operand pairs into the tile, steps the tile opcode cycle by cycle, reads the tile result register back over the shared bidirectional operand bus, and returns the result through a valid/ready port. It sits between the layer scheduler and each compute tile, and is the only driver of the tile's opcode, input0 and clear pins.

---
 rtl/tile_sequencer_if.sv | 33 +++
 rtl/tile_sequencer.sv | 123 ++++++++++++
 tb/tb_tile_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tile_sequencer_if.sv
// rtl/tile_sequencer_if.sv - command, operand, result and tile-pin bundle for tile_sequencer
interface tile_sequencer_if #(
    parameter int DW    = 16,
    parameter int LEN_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_op;
    logic [LEN_W-1:0] cmd_len;
    logic             op_valid;
    logic             op_ready;
    logic [DW-1:0]    op_a;
    logic [DW-1:0]    op_b;
    logic             res_valid;
    logic             res_ready;
    logic [DW-1:0]    res_data;
    logic             res_err;
    logic [3:0]       tile_opcode;
    logic [DW-1:0]    tile_in0;
    logic             tile_clear;

    modport master (
        output cmd_valid, cmd_op, cmd_len, op_valid, op_a, op_b, res_ready,
        input  cmd_ready, op_ready, res_valid, res_data, res_err,
               tile_opcode, tile_in0, tile_clear
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_len, op_valid, op_a, op_b, res_ready,
        output cmd_ready, op_ready, res_valid, res_data, res_err,
               tile_opcode, tile_in0, tile_clear
    );
endinterface

// File: rtl/tile_sequencer.sv
// rtl/tile_sequencer.sv - command sequencer driving one compute tile's opcode, operands and readback bus
module tile_sequencer #(
    parameter int DW    = 16,
    parameter int LEN_W = 8
) (
    input  logic           clk,
    input  logic           clear,
    tile_sequencer_if.slave bus,
    inout  wire  [DW-1:0]  tile_in1
);
    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_OPER, S_MAC, S_READ, S_RESP
    } state_t;

    localparam logic [3:0] OP_READ = 4'b1000;
    localparam logic [3:0] OP_MAC  = 4'b1111;

    state_t           state_q, state_d;
    logic [3:0]       op_q;
    logic [LEN_W-1:0] cnt_q;
    logic [DW-1:0]    res_data_q;
    logic             res_err_q;
    logic             tile_clear_q;

    logic             cmd_ready;
    logic             op_ready;
    logic [3:0]       tile_opcode;
    logic             cmd_fire;
    logic             cmd_illegal;

    assign cmd_fire    = (state_q == S_IDLE) && clear && bus.cmd_valid;
    assign cmd_illegal = bus.cmd_op[3] && (bus.cmd_op != OP_READ) && (bus.cmd_op != OP_MAC);

    always_ff @(posedge clk) begin
        if (!clear) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    if (!bus.cmd_op[3]) begin
                        state_d = S_OPER;
                    end else if (bus.cmd_op == OP_MAC) begin
                        state_d = S_CLR;
                    end else if (bus.cmd_op == OP_READ) begin
                        state_d = S_READ;
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end
            S_CLR:  state_d = (cnt_q == '0) ? S_READ : S_MAC;
            S_OPER: if (bus.op_valid) state_d = S_READ;
            S_MAC:  if (bus.op_valid && (cnt_q == LEN_W'(1))) state_d = S_READ;
            S_READ: state_d = S_RESP;
            S_RESP: if (bus.res_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake readies and the opcode are gated by clear so a reset cycle never consumes or writes.
    always_comb begin
        cmd_ready   = 1'b0;
        op_ready    = 1'b0;
        tile_opcode = OP_READ;
        if (clear) begin
            case (state_q)
                S_IDLE: cmd_ready = 1'b1;
                S_OPER: begin
                    op_ready = 1'b1;
                    if (bus.op_valid) tile_opcode = op_q;
                end
                S_MAC: begin
                    op_ready = 1'b1;
                    if (bus.op_valid) tile_opcode = OP_MAC;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!clear) begin
            op_q         <= OP_READ;
            cnt_q        <= '0;
            res_data_q   <= '0;
            res_err_q    <= 1'b0;
            tile_clear_q <= 1'b1;
        end else begin
            tile_clear_q <= (state_d == S_CLR);
            if (cmd_fire) begin
                op_q       <= bus.cmd_op;
                cnt_q      <= bus.cmd_len;
                res_data_q <= '0;
                res_err_q  <= cmd_illegal;
            end
            if ((state_q == S_MAC) && bus.op_valid) begin
                cnt_q <= cnt_q - LEN_W'(1);
            end
            if (state_q == S_READ) begin
                res_data_q <= tile_in1;
            end
        end
    end

    assign bus.cmd_ready   = cmd_ready;
    assign bus.op_ready    = op_ready;
    assign bus.tile_opcode = tile_opcode;
    assign bus.tile_in0    = bus.op_a;
    assign bus.tile_clear  = tile_clear_q | ~clear;
    assign bus.res_valid   = (state_q == S_RESP);
    assign bus.res_data    = res_data_q;
    assign bus.res_err     = res_err_q;

    // The tile owns input1 whenever it is in READ, so release the bus on exactly that code.
    assign tile_in1 = (tile_opcode != OP_READ) ? bus.op_b : {DW{1'bz}};
endmodule

// File: tb/tb_tile_sequencer.sv
// tb/tb_tile_sequencer.sv - scoreboard bench for tile_sequencer with a behavioural tile
module tb_tile_sequencer;
    logic        clk;
    logic        clear;
    wire  [15:0] tile_in1;
    logic [15:0] tile_q;

    tile_sequencer_if #(.DW(16), .LEN_W(8)) bus ();

    tile_sequencer #(.DW(16), .LEN_W(8)) dut (
        .clk      (clk),
        .clear    (clear),
        .bus      (bus),
        .tile_in1 (tile_in1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural tile: clear wins, 1000 holds and drives the register onto input1.
    always @(posedge clk) begin
        if (bus.tile_clear) begin
            tile_q <= 16'h0000;
        end else begin
            case (bus.tile_opcode)
                4'b0000: tile_q <= bus.tile_in0 & tile_in1;
                4'b0001: tile_q <= bus.tile_in0 | tile_in1;
                4'b0010: tile_q <= bus.tile_in0 ^ tile_in1;
                4'b0011: tile_q <= bus.tile_in0 + tile_in1;
                4'b0100: tile_q <= bus.tile_in0 - tile_in1;
                4'b0101: tile_q <= bus.tile_in0 * tile_in1;
                4'b0110: tile_q <= bus.tile_in0 << tile_in1[3:0];
                4'b0111: tile_q <= tile_in1;
                4'b1111: tile_q <= tile_q + bus.tile_in0 * tile_in1;
                default: tile_q <= tile_q;
            endcase
        end
    end
    assign tile_in1 = (bus.tile_opcode == 4'b1000) ? tile_q : 16'bz;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        logic [15:0] d;
        logic        e;
        int          at;
    } exp_t;
    exp_t sb[$];

    logic [15:0] pa [0:7];
    logic [15:0] pb [0:7];
    int          st [0:7];
    int          bp_left = 0;

    int wr_cnt, clr_cnt, clr_cyc, mac_cyc;

    // Response-side monitor: latency, data, err, hold stability and cmd_ready around the response.
    bit          in_resp = 0;
    bit          post_hs = 0;
    int          rise;
    logic [15:0] held_d;
    logic        held_e;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (post_hs) begin
                post_hs = 0;
                if (clear) check("cmd_ready_after_resp", 32'(bus.cmd_ready), 1);
            end
            if (bus.res_valid) begin
                if (!in_resp) begin
                    in_resp = 1;
                    rise    = cyc;
                    held_d  = bus.res_data;
                    held_e  = bus.res_err;
                    check("cmd_ready_busy", 32'(bus.cmd_ready), 0);
                end else begin
                    check("res_data_stable", 32'(bus.res_data), 32'(held_d));
                    check("res_err_stable", 32'(bus.res_err), 32'(held_e));
                end
                if (bus.res_ready) begin
                    in_resp = 0;
                    post_hs = 1;
                    if (sb.size() == 0) begin
                        check("unexpected_resp", 32'(bus.res_valid), 0);
                    end else begin
                        e = sb.pop_front();
                        check("res_data", 32'(bus.res_data), 32'(e.d));
                        check("res_err", 32'(bus.res_err), 32'(e.e));
                        check("res_latency_cycle", 32'(rise), 32'(e.at));
                    end
                end
            end
        end
    end

    // Tile-side monitor: bus ownership every cycle plus write/clear activity counters.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (bus.tile_opcode == 4'b1000) check("bus_released", 32'(tile_in1), 32'(tile_q));
            else                            check("bus_driven", 32'(tile_in1), 32'(bus.op_b));
            check("tile_in0", 32'(bus.tile_in0), 32'(bus.op_a));
            if (clear) begin
                if (bus.tile_clear) begin
                    clr_cnt++;
                    if (clr_cyc < 0) clr_cyc = cyc;
                end
                if (bus.tile_opcode != 4'b1000) wr_cnt++;
                if (bus.tile_opcode == 4'b1111 && mac_cyc < 0) mac_cyc = cyc;
            end
        end
    end

    initial begin
        bus.res_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.res_valid && bp_left > 0) begin
                bus.res_ready = 1'b0;
                bp_left--;
            end else begin
                bus.res_ready = 1'b1;
            end
        end
    end

    task automatic set_pair(input int i, input logic [15:0] a, input logic [15:0] b, input int s);
        pa[i] = a;
        pb[i] = b;
        st[i] = s;
    endtask

    task automatic wait_cmd_ready();
        int t = 0;
        #1;
        while (!bus.cmd_ready && t < 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("cmd_ready_wait", 32'(bus.cmd_ready), 1);
    endtask

    task automatic wait_op_ready();
        int t = 0;
        #1;
        while (!bus.op_ready && t < 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("op_ready_wait", 32'(bus.op_ready), 1);
    endtask

    task automatic wait_done();
        int t = 0;
        @(negedge clk);
        #3;
        while ((sb.size() != 0 || bus.res_valid) && t < 300) begin
            @(negedge clk);
            #3;
            t++;
        end
        check("resp_drained", 32'(sb.size()), 0);
    endtask

    task automatic run_cmd(input logic [3:0] op, input logic [7:0] len, input int npairs,
                           input logic [15:0] exp_d, input logic exp_e, input int lat,
                           input int exp_wr);
        exp_t e;
        @(negedge clk);
        wr_cnt  = 0;
        clr_cnt = 0;
        clr_cyc = -1;
        mac_cyc = -1;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_len   = len;
        wait_cmd_ready();
        e.d  = exp_d;
        e.e  = exp_e;
        e.at = cyc + lat;
        sb.push_back(e);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < npairs; i++) begin
            repeat (st[i]) begin
                bus.op_valid = 1'b0;
                bus.op_a     = 16'hffff;
                bus.op_b     = 16'hffff;
                @(negedge clk);
            end
            bus.op_valid = 1'b1;
            bus.op_a     = pa[i];
            bus.op_b     = pb[i];
            wait_op_ready();
            @(negedge clk);
        end
        bus.op_valid = 1'b0;
        bus.op_a     = 16'hffff;
        bus.op_b     = 16'hffff;
        wait_done();
        check("tile_write_cycles", 32'(wr_cnt), 32'(exp_wr));
        check("tile_clear_cycles", 32'(clr_cnt), (op == 4'hf) ? 32'd1 : 32'd0);
        if (op == 4'hf && npairs > 0 && st[0] == 0)
            check("clear_before_first_beat", 32'(mac_cyc), 32'(clr_cyc + 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        clear         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 4'h0;
        bus.cmd_len   = 8'h00;
        bus.op_valid  = 1'b0;
        bus.op_a      = 16'hffff;
        bus.op_b      = 16'hffff;
        tile_q        = 16'h0000;
        for (int i = 0; i < 8; i++) set_pair(i, 16'h0, 16'h0, 0);

        repeat (3) @(negedge clk);
        #1;
        check("rst_res_valid", 32'(bus.res_valid), 0);
        check("rst_res_data", 32'(bus.res_data), 0);
        check("rst_res_err", 32'(bus.res_err), 0);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 0);
        check("rst_op_ready", 32'(bus.op_ready), 0);
        check("rst_tile_clear", 32'(bus.tile_clear), 1);
        check("rst_tile_opcode", 32'(bus.tile_opcode), 32'h8);
        @(negedge clk);
        clear = 1'b1;
        #1;
        check("idle_cmd_ready", 32'(bus.cmd_ready), 1);

        set_pair(0, 16'd5, 16'd7, 0);
        run_cmd(4'b0011, 8'd0, 1, 16'd12, 1'b0, 3, 1);

        set_pair(0, 16'd3, 16'd5, 0);
        run_cmd(4'b0100, 8'd0, 1, 16'hfffe, 1'b0, 3, 1);

        set_pair(0, 16'h0100, 16'h0023, 1);
        run_cmd(4'b0011, 8'd0, 1, 16'h0123, 1'b0, 4, 1);

        set_pair(0, 16'd2, 16'd3, 0);
        set_pair(1, 16'd4, 16'd5, 0);
        set_pair(2, 16'd1, 16'd10, 0);
        run_cmd(4'b1111, 8'd3, 3, 16'd36, 1'b0, 6, 3);

        set_pair(0, 16'd3, 16'd4, 0);
        set_pair(1, 16'd5, 16'd6, 2);
        bp_left = 4;
        run_cmd(4'b1111, 8'd2, 2, 16'd42, 1'b0, 7, 2);

        run_cmd(4'b1010, 8'd0, 0, 16'd0, 1'b1, 1, 0);
        run_cmd(4'b1111, 8'd0, 0, 16'd0, 1'b0, 3, 0);

        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 4'b1111;
        bus.cmd_len   = 8'd4;
        wait_cmd_ready();
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.op_valid = 1'b1;
            bus.op_a     = 16'd2;
            bus.op_b     = 16'd2;
            wait_op_ready();
            @(negedge clk);
        end
        clear = 1'b0;
        #1;
        check("midrst_cmd_ready", 32'(bus.cmd_ready), 0);
        check("midrst_op_ready", 32'(bus.op_ready), 0);
        check("midrst_tile_opcode", 32'(bus.tile_opcode), 32'h8);
        check("midrst_tile_clear", 32'(bus.tile_clear), 1);
        @(negedge clk);
        clear        = 1'b1;
        bus.op_valid = 1'b0;
        bus.op_a     = 16'hffff;
        bus.op_b     = 16'hffff;
        #1;
        check("postrst_idle", 32'(bus.cmd_ready), 1);
        check("postrst_tile_clear", 32'(bus.tile_clear), 1);
        check("postrst_res_data", 32'(bus.res_data), 0);
        repeat (4) begin
            check("postrst_no_resp", 32'(bus.res_valid), 0);
            @(negedge clk);
            #1;
        end

        set_pair(0, 16'd1, 16'd1, 0);
        run_cmd(4'b0011, 8'd0, 1, 16'd2, 1'b0, 3, 1);

        set_pair(0, 16'h8000, 16'd2, 0);
        set_pair(1, 16'd1, 16'd1, 0);
        run_cmd(4'b1111, 8'd2, 2, 16'h0001, 1'b0, 5, 2);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
